mips_dmem_bus_bridge: RTL

- Downstream neighbour of the Harvard CPU's data port. Converts the single-cycle data_read/data_write strobes into Avalon-MM-style transactions with waitrequest.
- Generates a stall that the top level uses to gate the CPU: cpu clk_enable = ext_enable & ~stall.
- Holds read data stable for the CPU's completing cycle.
- Bounds every bus transaction with a timeout and flags bus errors.

---
 rtl/mips_bus_pkg.sv | 17 +
 rtl/mips_dmem_bus_bridge_if.sv | 25 ++
 rtl/dbridge_timeout_ctr.sv | 35 +++
 rtl/mips_dmem_bus_bridge.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the CPU data-memory bus bridge
// Contents:
//   dbridge_state_t      bridge FSM state (IDLE, REQ, DONE)
//   BYTEEN_WORD          byte enable for full-word transfers
//   ERR_READDATA_DEFAULT load data returned for a timed-out read
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dbridge_state_t;

  localparam logic [3:0]  BYTEEN_WORD          = 4'hF;
  localparam logic [31:0] ERR_READDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mips_dmem_bus_bridge_if.sv
// rtl/mips_dmem_bus_bridge_if.sv - Avalon-MM-style data bus between bridge and memory
// Signals:
//   avm_address/avm_read/avm_write/avm_writedata/avm_byteenable  driven by the master (bridge)
//   avm_readdata/avm_waitrequest                                   driven by the slave (memory)
interface mips_dmem_bus_bridge_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/dbridge_timeout_ctr.sv
// rtl/dbridge_timeout_ctr.sv - loadable saturating up-counter with clear and terminal-count flag
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             synchronous clear to zero (wins over load/inc)
//   load, load_value  synchronous load
//   inc               count up by one, holding at all-ones
//   count             current value
//   terminal          high while count equals TERMINAL
module dbridge_timeout_ctr #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERMINAL);

endmodule

// File: rtl/mips_dmem_bus_bridge.sv
// rtl/mips_dmem_bus_bridge.sv - turns CPU data_read/data_write strobes into bus transactions with stall
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ext_enable              external clock enable (CPU runs on ext_enable & ~stall)
//   data_address/data_read/data_write/data_writedata   CPU data port request
//   data_readdata           load data to the CPU, held stable in DONE
//   stall                   combinational CPU hold
//   avm                     bus master port (mips_dmem_bus_bridge_if.master)
//   bus_error               sticky: timeout, read+write together, or misaligned address
//   perf_stall_cycles       stall-cycle counter when DBRIDGE_PERF_EN is defined, else 0
// Build option: DBRIDGE_PERF_EN enables the saturating stall-cycle counter.
module mips_dmem_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_READDATA   = ERR_READDATA_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ext_enable,
  input  logic [31:0]                    data_address,
  input  logic                           data_read,
  input  logic                           data_write,
  input  logic [31:0]                    data_writedata,
  output logic [31:0]                    data_readdata,
  output logic                           stall,
  mips_dmem_bus_bridge_if.master         avm,
  output logic                           bus_error,
  output logic [31:0]                    perf_stall_cycles
);

  localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  dbridge_state_t state, state_n;

  logic        req;
  logic [31:0] address_n, writedata_n, readdata_n;
  logic        read_n, write_n, error_n;
  logic        to_clear, to_inc, to_last;
  logic [TW-1:0] timeout_count_unused;

  assign req                = data_read | data_write;
  assign avm.avm_byteenable = BYTEEN_WORD;

  // Counts REQ cycles spent waiting; terminal fires on the last allowed wait cycle.
  dbridge_timeout_ctr #(
    .WIDTH    (TW),
    .TERMINAL (TO_LAST)
  ) u_timeout_ctr (
    .clk        (clk),
    .reset      (reset),
    .clear      (to_clear),
    .load       (1'b0),
    .load_value ({TW{1'b0}}),
    .inc        (to_inc),
    .count      (timeout_count_unused),
    .terminal   (to_last)
  );

  always_comb begin
    state_n     = state;
    address_n   = avm.avm_address;
    writedata_n = avm.avm_writedata;
    read_n      = avm.avm_read;
    write_n     = avm.avm_write;
    readdata_n  = data_readdata;
    error_n     = bus_error;
    stall       = 1'b0;
    to_clear    = 1'b0;
    to_inc      = 1'b0;

    unique case (state)
      IDLE: begin
        stall = ext_enable & req;
        if (ext_enable && req) begin
          address_n   = {data_address[31:2], 2'b00};
          writedata_n = data_writedata;
          // read+write together is illegal: the write wins
          write_n     = data_write;
          read_n      = data_read & ~data_write;
          if ((data_read && data_write) || (data_address[1:0] != 2'b00)) begin
            error_n = 1'b1;
          end
          state_n = REQ;
        end
      end

      REQ: begin
        stall = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (avm.avm_read) readdata_n = avm.avm_readdata;
          read_n   = 1'b0;
          write_n  = 1'b0;
          to_clear = 1'b1;
          state_n  = DONE;
        end else if (to_last) begin
          if (avm.avm_read) readdata_n = ERR_READDATA;
          read_n   = 1'b0;
          write_n  = 1'b0;
          error_n  = 1'b1;
          to_clear = 1'b1;
          state_n  = DONE;
        end else begin
          to_inc = 1'b1;
        end
      end

      DONE: begin
        // CPU advances on this edge only when enabled; otherwise wait here so the
        // still-present request is not re-issued.
        if (ext_enable) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      avm.avm_address   <= 32'h0;
      avm.avm_writedata <= 32'h0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
      data_readdata     <= 32'h0;
      bus_error         <= 1'b0;
    end else begin
      state             <= state_n;
      avm.avm_address   <= address_n;
      avm.avm_writedata <= writedata_n;
      avm.avm_read      <= read_n;
      avm.avm_write     <= write_n;
      data_readdata     <= readdata_n;
      bus_error         <= error_n;
    end
  end

`ifdef DBRIDGE_PERF_EN
  logic perf_full;

  dbridge_timeout_ctr #(
    .WIDTH    (32),
    .TERMINAL (32'hFFFF_FFFF)
  ) u_perf_ctr (
    .clk        (clk),
    .reset      (reset),
    .clear      (1'b0),
    .load       (1'b0),
    .load_value (32'h0),
    .inc        (stall & ~perf_full),
    .count      (perf_stall_cycles),
    .terminal   (perf_full)
  );
`else
  assign perf_stall_cycles = 32'h0;
`endif

endmodule
